// File: rtl/axis_stream_checker_pkg.sv
// axis_checker_pkg: shared state type, mode codes and LFSR constants for the stream checker
package axis_checker_pkg;
  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
  localparam int MODE_CONST = 0;
  localparam int MODE_INCR = 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/axis_stream_checker_if.sv
// axis_stream_checker_if: AXI4-Stream handshake and payload bundle
interface axis_stream_checker_if #(parameter int DATA_W = 32);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DATA_W-1:0] tdata;
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_stream_checker_lfsr16_ready_gen.sv
// lfsr16_ready_gen: enable-stepped x^16+x^14+x^13+x^11+1 Fibonacci LFSR giving a backpressure bit
module lfsr16_ready_gen
  import axis_checker_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic ready_bit
);
  logic [15:0] q;
  // shift in the tap parity whenever the checker is running
  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
  end
  assign ready_bit = q[0];
endmodule

// File: rtl/axis_stream_checker.sv
// axis_stream_checker: AXI4-Stream sink that checks a masked data field and frame length in hardware
module axis_stream_checker
  import axis_checker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CMP_LSB = 0,
  parameter int CMP_W = 8,
  parameter int EXP_BASE = 42,
  parameter int MODE = 0,
  parameter int FRAME_LEN = 16,
  parameter int NUM_FRAMES = 4,
  parameter int START_DELAY = 20000,
  parameter int BP_EN = 0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  axis_stream_checker_if.slave s,
  output logic [CNT_W-1:0] data_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic first_err_vld,
  output logic [DATA_W-1:0] first_err_data,
  output logic [15:0] first_err_idx,
  output logic done,
  output logic pass
);
  state_t state, next_state;
  logic [31:0] hold_cnt;
  logic [15:0] beat_idx;
  logic ready, lfsr_bit, hs, last_pos, frame_end, go, fin;
  logic [CMP_W-1:0] exp_val;
  logic s1_vld, s1_end, s1_lerr;
  logic [DATA_W-1:0] s1_data;
  logic [15:0] s1_idx;
  logic [CMP_W-1:0] s1_exp;
  logic s2_mis, s2_end, s2_lerr;
  logic [DATA_W-1:0] s2_data;
  logic [15:0] s2_idx;

  lfsr16_ready_gen u_lfsr (.clk(clk), .reset(reset), .en(state == RUN), .ready_bit(lfsr_bit));

  assign go = START_DELAY <= 1 || hold_cnt == 32'(START_DELAY - 1);
  assign fin = NUM_FRAMES != 0 && 32'(frame_cnt) >= 32'(NUM_FRAMES);
  assign hs = s.tvalid & ready;
  assign s.tready = ready;
  assign last_pos = beat_idx == 16'(FRAME_LEN - 1);
  assign frame_end = s.tlast | last_pos;
  assign exp_val = MODE == MODE_CONST ? CMP_W'(EXP_BASE) : CMP_W'(32'(EXP_BASE) + 32'(beat_idx));
  assign done = state == DONE;
  assign pass = done && data_err_cnt == '0 && len_err_cnt == '0;

  // hold-off, run until enough frames, then stay done
  always_comb begin
    next_state = state == HOLD && go ? RUN : state == RUN && fin ? DONE : state;
  end

  // state, hold-off counter and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOLD;
      hold_cnt <= '0;
      ready <= 1'b0;
    end else begin
      state <= next_state;
      hold_cnt <= state == HOLD ? hold_cnt + 1'b1 : hold_cnt;
      ready <= next_state == RUN && (BP_EN == 0 || lfsr_bit);
    end
  end

  // stage 1: capture accepted beat, its index, expected value and framing result
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_idx <= '0;
      s1_vld <= 1'b0;
      s1_end <= 1'b0;
      s1_lerr <= 1'b0;
      s1_data <= '0;
      s1_idx <= '0;
      s1_exp <= '0;
    end else begin
      s1_vld <= hs;
      s1_end <= hs & frame_end;
      s1_lerr <= hs & (s.tlast ^ last_pos);
      if (hs) begin
        beat_idx <= frame_end ? '0 : beat_idx + 1'b1;
        s1_data <= s.tdata;
        s1_idx <= beat_idx;
        s1_exp <= exp_val;
      end
    end
  end

  // stage 2: compare the masked field
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_mis <= 1'b0;
      s2_end <= 1'b0;
      s2_lerr <= 1'b0;
      s2_data <= '0;
      s2_idx <= '0;
    end else begin
      s2_mis <= s1_vld && s1_data[CMP_LSB +: CMP_W] != s1_exp;
      s2_end <= s1_end;
      s2_lerr <= s1_lerr;
      s2_data <= s1_data;
      s2_idx <= s1_idx;
    end
  end

  // saturating counters and first-error capture
  always_ff @(posedge clk) begin
    if (reset) begin
      data_err_cnt <= '0;
      len_err_cnt <= '0;
      frame_cnt <= '0;
      first_err_vld <= 1'b0;
      first_err_data <= '0;
      first_err_idx <= '0;
    end else begin
      if (s2_mis && !(&data_err_cnt)) data_err_cnt <= data_err_cnt + 1'b1;
      if (s2_lerr && !(&len_err_cnt)) len_err_cnt <= len_err_cnt + 1'b1;
      if (s2_end && !(&frame_cnt)) frame_cnt <= frame_cnt + 1'b1;
      if (s2_mis && !first_err_vld) begin
        first_err_vld <= 1'b1;
        first_err_data <= s2_data;
        first_err_idx <= s2_idx;
      end
    end
  end
endmodule

// File: tb/tb_axis_stream_checker.sv
// tb_axis_stream_checker: directed and table-driven checks of axis_stream_checker across four configurations
module tb_axis_stream_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst = 4'hF;
  logic vld = 1'b0;
  logic lst = 1'b0;
  logic [31:0] dat = '0;
  int checks = 0;
  int fails = 0;

  axis_stream_checker_if #(.DATA_W(32)) if0 (), if1 (), if2 (), if3 ();
  assign {if0.tvalid, if0.tdata, if0.tlast} = {vld, dat, lst};
  assign {if1.tvalid, if1.tdata, if1.tlast} = {vld, dat, lst};
  assign {if2.tvalid, if2.tdata, if2.tlast} = {vld, dat, lst};
  assign {if3.tvalid, if3.tdata, if3.tlast} = {vld, dat, lst};

  logic [15:0] derr [3];
  logic [15:0] lerr [3];
  logic [15:0] fcnt [3];
  logic [15:0] fidx [4];
  logic [3:0] derr3, lerr3, fcnt3;
  logic [31:0] fdat [4];
  logic fev [4];
  logic dn [4];
  logic ps [4];

  axis_stream_checker #(.START_DELAY(10)) u0 (
    .clk(clk), .reset(rst[0]), .s(if0), .data_err_cnt(derr[0]), .len_err_cnt(lerr[0]), .frame_cnt(fcnt[0]),
    .first_err_vld(fev[0]), .first_err_data(fdat[0]), .first_err_idx(fidx[0]), .done(dn[0]), .pass(ps[0]));
  axis_stream_checker #(.MODE(1), .EXP_BASE(250), .FRAME_LEN(8), .NUM_FRAMES(2), .START_DELAY(3)) u1 (
    .clk(clk), .reset(rst[1]), .s(if1), .data_err_cnt(derr[1]), .len_err_cnt(lerr[1]), .frame_cnt(fcnt[1]),
    .first_err_vld(fev[1]), .first_err_data(fdat[1]), .first_err_idx(fidx[1]), .done(dn[1]), .pass(ps[1]));
  axis_stream_checker #(.BP_EN(1), .START_DELAY(2)) u2 (
    .clk(clk), .reset(rst[2]), .s(if2), .data_err_cnt(derr[2]), .len_err_cnt(lerr[2]), .frame_cnt(fcnt[2]),
    .first_err_vld(fev[2]), .first_err_data(fdat[2]), .first_err_idx(fidx[2]), .done(dn[2]), .pass(ps[2]));
  axis_stream_checker #(.CNT_W(4), .NUM_FRAMES(0), .START_DELAY(2)) u3 (
    .clk(clk), .reset(rst[3]), .s(if3), .data_err_cnt(derr3), .len_err_cnt(lerr3), .frame_cnt(fcnt3),
    .first_err_vld(fev[3]), .first_err_data(fdat[3]), .first_err_idx(fidx[3]), .done(dn[3]), .pass(ps[3]));

  typedef struct {
    logic [31:0] data;
    logic last;
    int derr;
    int lerr;
    int frames;
    int fev;
    int fidx;
  } vec_t;
  vec_t tab [16];

  function automatic logic rdy(input int d);
    return d == 0 ? if0.tready : d == 1 ? if1.tready : d == 2 ? if2.tready : if3.tready;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // present one beat at a negedge and return at the negedge after its handshake
  task automatic send(input int d, input logic [31:0] data, input logic last);
    int n = 0;
    vld = 1'b1;
    dat = data;
    lst = last;
    while (!rdy(d) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      fails++;
      $display("FAIL send_timeout dut=%0d actual=no_ready expected=ready", d);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  // release u0 from reset and verify ready stays low for the whole hold-off
  task automatic holdoff(input int n);
    rst[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("holdoff_ready", rdy(0), 0);
      @(negedge clk);
    end
    chk("run_ready", rdy(0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{32'h0000_00FA, 1'b0, 0, 0, 0, 0, 0};
    tab[1]  = '{32'h0000_00FB, 1'b0, 0, 0, 0, 0, 0};
    tab[2]  = '{32'h0000_00FC, 1'b0, 0, 0, 0, 0, 0};
    tab[3]  = '{32'h0000_00FD, 1'b0, 0, 0, 0, 0, 0};
    tab[4]  = '{32'h0000_00FE, 1'b0, 0, 0, 0, 0, 0};
    tab[5]  = '{32'hABCD_1200, 1'b0, 1, 0, 0, 1, 5};
    tab[6]  = '{32'h0000_0000, 1'b0, 1, 0, 0, 1, 5};
    tab[7]  = '{32'h0000_0001, 1'b1, 1, 0, 1, 1, 5};
    tab[8]  = '{32'h5A5A_5AFA, 1'b0, 1, 0, 1, 1, 5};
    tab[9]  = '{32'h5A5A_5AFB, 1'b0, 1, 0, 1, 1, 5};
    tab[10] = '{32'h5A5A_5A10, 1'b0, 2, 0, 1, 1, 5};
    tab[11] = '{32'h5A5A_5AFD, 1'b0, 2, 0, 1, 1, 5};
    tab[12] = '{32'h5A5A_5AFE, 1'b0, 2, 0, 1, 1, 5};
    tab[13] = '{32'h5A5A_5AFF, 1'b0, 2, 0, 1, 1, 5};
    tab[14] = '{32'h5A5A_5A00, 1'b0, 2, 0, 1, 1, 5};
    tab[15] = '{32'h5A5A_5A01, 1'b1, 2, 0, 2, 1, 5};
    repeat (3) @(negedge clk);

    vld = 1'b1;
    dat = 32'h2A;
    holdoff(10);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_derr", derr[0], 0);
    chk("hold_frames", fcnt[0], 0);
    chk("hold_done", dn[0], 0);

    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 16; b++) send(0, 32'h2A, b == 15);
    repeat (4) @(negedge clk);
    chk("const_done", dn[0], 1);
    chk("const_pass", ps[0], 1);
    chk("const_frames", fcnt[0], 4);
    chk("const_derr", derr[0], 0);
    chk("const_lerr", lerr[0], 0);
    chk("done_ready", rdy(0), 0);

    rst[0] = 1'b1;
    @(negedge clk);
    chk("rst_done", dn[0], 0);
    chk("rst_pass", ps[0], 0);
    chk("rst_frames", fcnt[0], 0);
    chk("rst_ready", rdy(0), 0);
    holdoff(10);
    for (int b = 0; b < 3; b++) send(0, 32'h2A, 1'b0);
    send(0, 32'h55, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_derr", derr[0], 1);
    chk("pre_rst_fev", fev[0], 1);
    chk("pre_rst_fidx", fidx[0], 3);
    chk("pre_rst_fdat", fdat[0], 32'h55);
    send(0, 32'h55, 1'b0);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_derr", derr[0], 0);
    chk("midrst_lerr", lerr[0], 0);
    chk("midrst_frames", fcnt[0], 0);
    chk("midrst_fev", fev[0], 0);
    chk("midrst_fdat", fdat[0], 0);
    chk("midrst_fidx", fidx[0], 0);
    chk("midrst_ready", rdy(0), 0);
    holdoff(10);
    chk("flush_derr", derr[0], 0);
    chk("flush_fev", fev[0], 0);

    for (int b = 0; b < 10; b++) send(0, 32'h2A, b == 9);
    repeat (2) @(negedge clk);
    chk("early_lerr", lerr[0], 1);
    chk("early_frames", fcnt[0], 1);
    for (int b = 0; b < 16; b++) send(0, 32'h2A, 1'b0);
    repeat (2) @(negedge clk);
    chk("miss_lerr", lerr[0], 2);
    chk("miss_frames", fcnt[0], 2);
    chk("miss_derr", derr[0], 0);
    chk("miss_done", dn[0], 0);
    rst[0] = 1'b1;

    rst[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(1, tab[i].data, tab[i].last);
      repeat (2) @(negedge clk);
      chk($sformatf("incr_derr[%0d]", i), derr[1], tab[i].derr);
      chk($sformatf("incr_lerr[%0d]", i), lerr[1], tab[i].lerr);
      chk($sformatf("incr_frames[%0d]", i), fcnt[1], tab[i].frames);
      chk($sformatf("incr_fev[%0d]", i), fev[1], tab[i].fev);
      chk($sformatf("incr_fidx[%0d]", i), fidx[1], tab[i].fidx);
    end
    repeat (3) @(negedge clk);
    chk("incr_done", dn[1], 1);
    chk("incr_pass", ps[1], 0);
    chk("incr_fdat", fdat[1], 32'hABCD_1200);
    chk("incr_ready", rdy(1), 0);
    rst[1] = 1'b1;

    rst[2] = 1'b0;
    for (int b = 0; b < 64; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(2, {24'(b), 8'h2A}, b % 16 == 15);
    end
    repeat (5) @(negedge clk);
    chk("bp_done", dn[2], 1);
    chk("bp_pass", ps[2], 1);
    chk("bp_frames", fcnt[2], 4);
    chk("bp_derr", derr[2], 0);
    chk("bp_lerr", lerr[2], 0);
    chk("bp_fev", fev[2], 0);
    chk("bp_fdat", fdat[2], 0);
    chk("bp_fidx", fidx[2], 0);
    rst[2] = 1'b1;

    rst[3] = 1'b0;
    for (int b = 0; b < 20; b++) send(3, 32'h1234_5600, b == 15);
    repeat (3) @(negedge clk);
    chk("sat_derr", derr3, 15);
    chk("sat_frames", fcnt3, 1);
    chk("sat_lerr", lerr3, 0);
    chk("sat_done", dn[3], 0);
    chk("sat_pass", ps[3], 0);
    chk("sat_fev", fev[3], 1);
    chk("sat_fidx", fidx[3], 0);
    chk("sat_fdat", fdat[3], 32'h1234_5600);
    rst[3] = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
